// File: rtl/pad_stream_source.sv
// Zero-border padding source: wraps an unpadded raster from a valid/ready upstream in a
// one-word border and presents it through a show-ahead FIFO-style read interface.
module pad_stream_source #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            WIDTH      = 112,
  parameter int unsigned            HEIGHT     = 112,
  parameter logic [DATA_WIDTH-1:0]  PAD_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3*DATA_WIDTH-1:0] pixel_in,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  output logic [3*DATA_WIDTH-1:0] data_out,
  output logic                    data_fifo_empty,
  input  logic                    rdreq,
  output logic                    frame_done
);

  localparam int unsigned ColW = $clog2(WIDTH + 2);
  localparam int unsigned RowW = $clog2(HEIGHT + 2);
  localparam logic [ColW-1:0] ColLast = ColW'(WIDTH + 1);
  localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT + 1);

  logic [ColW-1:0]         col_q, col_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [3*DATA_WIDTH-1:0] data_q, data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    last_q, last_d;
  logic                    frame_done_q, frame_done_d;

  logic border, pop, slot_free, load;

  always_comb begin
    border    = (row_q == '0) || (row_q == RowLast) || (col_q == '0) || (col_q == ColLast);
    pop       = rdreq & out_valid_q;
    slot_free = ~out_valid_q | pop;
    load      = slot_free & (border | pixel_valid);

    col_d        = col_q;
    row_d        = row_q;
    data_d       = data_q;
    out_valid_d  = out_valid_q;
    last_d       = last_q;
    frame_done_d = pop & last_q;

    if (load) begin
      data_d      = border ? {3{PAD_VALUE}} : pixel_in;
      out_valid_d = 1'b1;
      // Tag rides with the word so frame_done fires on its pop, not its load.
      last_d      = (row_q == RowLast) && (col_q == ColLast);
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      data_q       <= '0;
      out_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pixel_ready     = ~border & slot_free;
  assign data_out        = data_q;
  assign data_fifo_empty = ~out_valid_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_pad_stream_source.sv
// Bench for pad_stream_source: scenario table on a 3x2 image checked against a padded-raster
// model, plus a default-size instance checked for words and pixels per frame.
module tb_pad_stream_source;

  localparam int W = 3;
  localparam int H = 2;
  localparam int PW = W + 2;
  localparam int WORDS = (W + 2) * (H + 2);
  localparam int PIXELS = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] pixel_in = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [95:0] data_out;
  logic        data_fifo_empty;
  logic        rdreq = 1'b0;
  logic        frame_done;

  logic        b_rst_n = 1'b0;
  logic [95:0] b_pixel_in = 96'h1;
  logic        b_pixel_valid = 1'b1;
  logic        b_pixel_ready;
  logic [95:0] b_data_out;
  logic        b_empty;
  logic        b_rdreq = 1'b1;
  logic        b_frame_done;

  always #5 clk = ~clk;

  pad_stream_source #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H), .PAD_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .data_out(data_out), .data_fifo_empty(data_fifo_empty),
    .rdreq(rdreq), .frame_done(frame_done)
  );

  pad_stream_source dut_big (
    .clk(clk), .rst(b_rst_n), .pixel_in(b_pixel_in), .pixel_valid(b_pixel_valid),
    .pixel_ready(b_pixel_ready), .data_out(b_data_out), .data_fifo_empty(b_empty),
    .rdreq(b_rdreq), .frame_done(b_frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int frames;
    bit rnd;
    int rd_off;     // rdreq held low on cycles 1..rd_off-1
    int stall_pix;  // pixel index whose delivery is stalled (-1: none)
    int stall_len;
    int stop_pops;  // nonzero: assert reset after this many pops
    bit full_rate;
  } scen_t;

  scen_t scens [7];

  logic [95:0] pix   [$];
  logic [95:0] exp_q [$];

  function automatic logic [95:0] mk_pix(int i);
    return {32'(32 + i), 32'(16 + i), 32'(i)};
  endfunction

  function automatic bit is_border(int pos);
    int r = pos / PW;
    int c = pos % PW;
    return (r == 0) || (r == H + 1) || (c == 0) || (c == W + 1);
  endfunction

  task automatic run(input int idx, input scen_t s);
    int pops = 0, next_pix = 0, stall_cnt = 0;
    int first_pop = -1, last_pop = -1;
    int total;
    bit fd_exp = 1'b0, finished = 1'b0, timed_out = 1'b1;
    logic [95:0] exp_ready;
    pix.delete();
    exp_q.delete();
    for (int i = 0; i < s.frames * PIXELS; i++)
      pix.push_back(s.rnd ? {$urandom, $urandom, $urandom} : mk_pix(i));
    for (int f = 0; f < s.frames; f++)
      for (int r = 0; r < H + 2; r++)
        for (int c = 0; c < W + 2; c++)
          exp_q.push_back(is_border(r * PW + c) ? 96'h0 :
                          pix[f * PIXELS + (r - 1) * W + (c - 1)]);
    total = (s.stop_pops != 0) ? s.stop_pops : exp_q.size();

    @(negedge clk);
    rst_n = 1'b0; pixel_valid = 1'b0; rdreq = 1'b0;
    @(negedge clk);
    #1;
    check($sformatf("s%0d reset empty", idx), 96'(data_fifo_empty), 96'(1));
    check($sformatf("s%0d reset ready", idx), 96'(pixel_ready), 96'(0));
    check($sformatf("s%0d reset frame_done", idx), 96'(frame_done), 96'(0));
    check($sformatf("s%0d reset data", idx), data_out, 96'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      pixel_in = (next_pix < pix.size()) ? pix[next_pix] : {$urandom, $urandom, $urandom};
      if (s.rnd) pixel_valid = ($urandom % 4) != 0;
      else if (next_pix == s.stall_pix && stall_cnt < s.stall_len) begin
        pixel_valid = 1'b0;
        stall_cnt++;
      end else pixel_valid = 1'b1;
      if (s.rnd) rdreq = (cyc == 0) || (($urandom % 3) != 0);
      else rdreq = (cyc == 0) || (cyc >= s.rd_off);
      if (finished) rdreq = 1'b0;
      #1;
      check($sformatf("s%0d frame_done c%0d", idx, cyc), 96'(frame_done), 96'(fd_exp));
      if (finished) begin
        timed_out = 1'b0;
        break;
      end
      exp_ready = 96'(!is_border((pops + (data_fifo_empty ? 0 : 1)) % WORDS) &&
                      (data_fifo_empty || rdreq));
      check($sformatf("s%0d ready c%0d", idx, cyc), 96'(pixel_ready), exp_ready);
      if (!data_fifo_empty)
        check($sformatf("s%0d data word%0d", idx, pops), data_out, exp_q[pops]);
      if (!s.rnd && s.rd_off > 0 && cyc >= 1 && cyc < s.rd_off)
        check($sformatf("s%0d held word c%0d", idx, cyc), 96'(data_fifo_empty), 96'(0));
      if (!s.rnd && s.stall_pix >= 0 && next_pix == s.stall_pix && stall_cnt == s.stall_len
          && !pixel_valid)
        check($sformatf("s%0d drained on stall", idx), 96'(data_fifo_empty), 96'(1));
      fd_exp = 1'b0;
      if (pixel_valid && pixel_ready) next_pix++;
      if (rdreq && !data_fifo_empty) begin
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        fd_exp = (pops % WORDS) == 0;
      end
      if (s.stop_pops != 0 && pops == s.stop_pops) begin
        #2 rst_n = 1'b0;
        #1;
        check($sformatf("s%0d async reset empty", idx), 96'(data_fifo_empty), 96'(1));
        check($sformatf("s%0d async reset data", idx), data_out, 96'h0);
        check($sformatf("s%0d async reset ready", idx), 96'(pixel_ready), 96'(0));
        timed_out = 1'b0;
        break;
      end
      if (pops == total) finished = 1'b1;
      @(negedge clk);
    end

    if (timed_out) check($sformatf("s%0d timeout", idx), 96'(pops), 96'(total));
    else if (s.stop_pops == 0) begin
      check($sformatf("s%0d pops", idx), 96'(pops), 96'(s.frames * WORDS));
      check($sformatf("s%0d pixels", idx), 96'(next_pix), 96'(s.frames * PIXELS));
      if (s.full_rate)
        check($sformatf("s%0d back-to-back span", idx), 96'(last_pop - first_pop),
              96'(s.frames * WORDS - 1));
    end
  endtask

  initial begin
    int bpops = 0, bhs = 0;
    bit bdone = 1'b0;
    scens[0] = '{frames: 1, rnd: 0, rd_off: 0,  stall_pix: -1, stall_len: 0, stop_pops: 0, full_rate: 1};
    scens[1] = '{frames: 1, rnd: 0, rd_off: 11, stall_pix: -1, stall_len: 0, stop_pops: 0, full_rate: 0};
    scens[2] = '{frames: 1, rnd: 0, rd_off: 0,  stall_pix: 1,  stall_len: 4, stop_pops: 0, full_rate: 0};
    scens[3] = '{frames: 2, rnd: 0, rd_off: 0,  stall_pix: -1, stall_len: 0, stop_pops: 0, full_rate: 1};
    scens[4] = '{frames: 1, rnd: 0, rd_off: 0,  stall_pix: -1, stall_len: 0, stop_pops: 9, full_rate: 0};
    scens[5] = '{frames: 1, rnd: 0, rd_off: 0,  stall_pix: -1, stall_len: 0, stop_pops: 0, full_rate: 1};
    scens[6] = '{frames: 3, rnd: 1, rd_off: 0,  stall_pix: -1, stall_len: 0, stop_pops: 0, full_rate: 0};

    for (int i = 0; i < 7; i++) run(i, scens[i]);

    @(negedge clk);
    b_rst_n = 1'b1;
    for (int cyc = 0; cyc < 14000; cyc++) begin
      @(negedge clk);
      #1;
      if (b_frame_done) begin
        bdone = 1'b1;
        break;
      end
      if (b_rdreq && !b_empty) bpops++;
      if (b_pixel_valid && b_pixel_ready) bhs++;
    end
    check("default frame_done seen", 96'(bdone), 96'(1));
    check("default words per frame", 96'(bpops), 96'(12996));
    check("default pixels per frame", 96'(bhs), 96'(12544));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_stream_source.md
Name: pad_stream_source

Overview:
- Producer side of the 3-channel pixel FIFO interface that the conv2d feature-map blocks consume: presents one RGB word, {B,G,R} each DATA_WIDTH, with an empty flag, and pops a word on rdreq.
- Accepts an unpadded WIDTH x HEIGHT image in raster order from upstream over a valid/ready handshake.
- Emits the zero-bordered (WIDTH+2) x (HEIGHT+2) raster that conv2D instances with line width WIDTH+2 expect.
- Frames repeat back-to-back without software intervention.

Parameters:
DATA_WIDTH, 32, bits per colour channel (IEEE-754 single).
WIDTH, 112, unpadded image columns.
HEIGHT, 112, unpadded image rows.
PAD_VALUE, 32'h0000_0000, value placed in every channel of border words.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
pixel_in  input  DATA_WIDTH*3  upstream pixel; [3DW-1:2DW]=B, [2DW-1:DW]=G, [DW-1:0]=R.
pixel_valid  input  1  pixel_in holds a valid pixel.
pixel_ready  output  1  pixel accepted this cycle when pixel_valid is also high.
data_out  output  DATA_WIDTH*3  show-ahead word, same channel packing; valid while data_fifo_empty=0.
data_fifo_empty  output  1  high when no word is presented.
rdreq  input  1  consumer pop request.
frame_done  output  1  one-cycle pulse when the last padded word of a frame is popped.

Behaviour:
- Reset (rst=0, async): data_out=0, data_fifo_empty=1, pixel_ready=0, frame_done=0, row=0, col=0, out_valid=0.
- Position counters: col runs 0..WIDTH+1 and row runs 0..HEIGHT+1.
- A position is border when row==0, row==HEIGHT+1, col==0 or col==WIDTH+1; otherwise it is interior.
- The output holds one show-ahead register with an out_valid flag; data_fifo_empty = ~out_valid.
- pop = rdreq & out_valid. rdreq while empty is ignored and does not change state.
- The register may load when slot_free = ~out_valid | pop.
- Border position: if slot_free, load {3{PAD_VALUE}} next edge. No upstream pixel is consumed.
- Interior position: pixel_ready = slot_free (combinational; may depend on rdreq). If pixel_valid & pixel_ready, load pixel_in next edge.
- On each load: out_valid=1 and the counters advance. col wraps WIDTH+1 -> 0 with row+1. row wraps HEIGHT+1 -> 0, so the next frame starts immediately.
- pop without load in the same cycle: out_valid=0.
- pop and load in the same cycle: register replaced and out_valid stays 1. This gives a sustained throughput of 1 word/clk.
- Latency: a border word, or an interior pixel accepted at edge N, is visible on data_out with data_fifo_empty=0 after edge N.
- pixel_ready is 0 at every border position and whenever the register is full and not being popped.
- frame_done=1 for the cycle after the pop of the word at (HEIGHT+1, WIDTH+1). A registered tag bit travels with that word.
- Upstream stall at an interior position: the register drains and data_fifo_empty rises. The counters hold and there is no duplication or skipping.
- Reset mid-frame: the partial frame is discarded and the next word emitted is position (0,0).
- Words per frame = (WIDTH+2)*(HEIGHT+2); pixels consumed = WIDTH*HEIGHT. Defaults: 12996 words, 12544 pixels.

Test Plan:
- WIDTH=3, HEIGHT=2, pixels p0..p5 (R=i, G=16+i, B=32+i), pixel_valid and rdreq held high -> 20 words popped on 20 consecutive clocks:
  - row 0: 5 zeros;
  - row 1: 0,p0,p1,p2,0;
  - row 2: 0,p3,p4,p5,0;
  - row 3: 5 zeros;
  - frame_done pulses once after the 20th pop.
- Same image with rdreq low for 10 cycles after reset -> first zero word presented, data_fifo_empty=0, pixel_ready=0, data_out stable. Sequence is unchanged once rdreq resumes.
- pixel_valid dropped for 4 cycles when p1 is due -> the word after p0 drains, data_fifo_empty=1 and counters frozen. Then p1 is output and the remaining sequence is exact.
- rdreq pulsed while data_fifo_empty=1 right after reset -> no state change. First pop still returns the (0,0) zero word.
- Two frames back-to-back (pixels 0..5, then 6..11) -> 40 words with correct borders, frame_done pulses at pop 20 and pop 40.
- rst asserted at word 9 of a frame -> outputs take reset values asynchronously. After release the stream restarts at (0,0) and 20 correct words follow.
- Default parameters -> exactly 12996 pops per frame, 12544 pixel handshakes.
